// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO responder: register offsets (by word index
// addr[4:2]) and the interconnect region this peripheral lives in.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_OUT    = 3'd0,
    GPIO_DIR    = 3'd1,
    GPIO_IN     = 3'd2,
    GPIO_EDGE   = 3'd3,
    GPIO_IRQ_EN = 3'd4
  } gpio_reg_e;

  localparam logic [3:0] GPIO_REGION_ID = 4'd2;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for a pin vector, plus a previous-value register so
// rising edges can be detected on the synchronized value.
module gpio_sync #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  // Purely register-derived, so the pulse lasts exactly one cycle.
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/gpio_responder.sv
// Memory-mapped GPIO peripheral: output/direction registers, synchronized
// inputs, sticky rising-edge flags with write-1-to-clear and a level interrupt.
module gpio_responder
  import gpio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NPINS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             we_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [NPINS-1:0] gpio_in_i,
  output logic [NPINS-1:0] gpio_out_o,
  output logic [NPINS-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [2:0]       reg_idx;
  logic [NPINS-1:0] wr_bits;
  logic [NPINS-1:0] clr_mask;
  logic [NPINS-1:0] pin_sync;
  logic [NPINS-1:0] pin_rise;
  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] dir_q, dir_d;
  logic [NPINS-1:0] edge_q, edge_d;
  logic [NPINS-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             unused_bus;

  assign reg_idx    = addr_i[4:2];
  assign wr_bits    = wdata_i[NPINS-1:0];
  assign unused_bus = ^{addr_i, wdata_i};

  gpio_sync #(.W(NPINS)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (gpio_in_i),
    .sync_o (pin_sync),
    .rise_o (pin_rise)
  );

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    irq_en_d = irq_en_q;
    clr_mask = '0;
    if (we_i) begin
      case (reg_idx)
        GPIO_OUT:    out_d    = wr_bits;
        GPIO_DIR:    dir_d    = wr_bits;
        GPIO_EDGE:   clr_mask = wr_bits;
        GPIO_IRQ_EN: irq_en_d = wr_bits;
        default:     ;
      endcase
    end
    // A rise arriving in the same cycle as its clear must not be lost.
    edge_d = (edge_q & ~clr_mask) | pin_rise;
  end

  always_comb begin
    rdata_d = '0;
    case (reg_idx)
      GPIO_OUT:    rdata_d[NPINS-1:0] = out_q;
      GPIO_DIR:    rdata_d[NPINS-1:0] = dir_q;
      GPIO_IN:     rdata_d[NPINS-1:0] = pin_sync;
      GPIO_EDGE:   rdata_d[NPINS-1:0] = edge_q;
      GPIO_IRQ_EN: rdata_d[NPINS-1:0] = irq_en_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      dir_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign gpio_out_o = out_q;
  assign gpio_oe_o  = dir_q;
  assign irq_o      = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_gpio_responder.sv
// Directed self-checking bench for gpio_responder: reset, register access,
// input synchronization, edge flags, interrupt and reserved-address handling.
module tb_gpio_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  gpioIn;
  logic [7:0]  gpioOut;
  logic [7:0]  gpioOe;
  logic        irq;

  int checks;
  int errors;

  gpio_responder #(.WIDTH(32), .NPINS(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .we_i       (we),
    .rdata_o    (rdata),
    .gpio_in_i  (gpioIn),
    .gpio_out_o (gpioOut),
    .gpio_oe_o  (gpioOe),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addrOf(input logic [2:0] off);
    return BASE | {27'd0, off, 2'b00};
  endfunction

  // One bus cycle: drive, let the edge happen, settle 1 time unit past it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr  = a;
    wdata = d;
    we    = w;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] expZero;
    expZero = 32'h0;
    applyStimulus(addrOf(3'd0), 32'hFF, 1'b1);
    applyStimulus(addrOf(3'd1), 32'hFF, 1'b1);
    applyStimulus(addrOf(3'd1), 32'h0, 1'b0);
    addr  = addrOf(3'd0);
    wdata = 32'h77;
    we    = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (gpioOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_gpio_out: got %h expected 00", gpioOut); end
    checks++;
    if (gpioOe !== 8'h00) begin errors++; $display("[TB] FAIL reset_gpio_oe: got %h expected 00", gpioOe); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (rdata !== expZero) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, expZero); end
    @(posedge clk);
    #1;
    we  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(addrOf(i[2:0]), 32'h0, 1'b0);
      checks++;
      if (rdata !== expZero) begin errors++; $display("[TB] FAIL reset_read_%0d: got %h expected %h", i, rdata, expZero); end
    end
  endtask

  task automatic test_out_dir();
    applyStimulus(addrOf(3'd0), 32'h0000_00A5, 1'b1);
    checks++;
    if (gpioOut !== 8'hA5) begin errors++; $display("[TB] FAIL out_pins: got %h expected A5", gpioOut); end
    applyStimulus(addrOf(3'd1), 32'h0000_000F, 1'b1);
    checks++;
    if (gpioOe !== 8'h0F) begin errors++; $display("[TB] FAIL dir_pins: got %h expected 0F", gpioOe); end
    applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL read_out: got %h expected 000000a5", rdata); end
    applyStimulus(addrOf(3'd1), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_000F) begin errors++; $display("[TB] FAIL read_dir: got %h expected 0000000f", rdata); end
    applyStimulus(addrOf(3'd0), 32'hFFFF_FF5A, 1'b1);
    checks++;
    if (gpioOut !== 8'h5A) begin errors++; $display("[TB] FAIL out_trunc_pins: got %h expected 5A", gpioOut); end
    applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_005A) begin errors++; $display("[TB] FAIL read_out_trunc: got %h expected 0000005a", rdata); end
    applyStimulus(addrOf(3'd0), 32'h0000_003C, 1'b1);
    checks++;
    if (rdata !== 32'h0000_005A) begin errors++; $display("[TB] FAIL same_cycle_rw: got %h expected 0000005a", rdata); end
    checks++;
    if (gpioOut !== 8'h3C) begin errors++; $display("[TB] FAIL same_cycle_pins: got %h expected 3C", gpioOut); end
    applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_003C) begin errors++; $display("[TB] FAIL read_out_new: got %h expected 0000003c", rdata); end
  endtask

  task automatic test_edge_irq();
    gpioIn = 8'h03;
    applyStimulus(addrOf(3'd2), 32'h0, 1'b0);
    applyStimulus(addrOf(3'd2), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL in_sync_depth: got %h expected 00000000", rdata); end
    applyStimulus(addrOf(3'd2), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0003) begin errors++; $display("[TB] FAIL in_read: got %h expected 00000003", rdata); end
    applyStimulus(addrOf(3'd3), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0003) begin errors++; $display("[TB] FAIL edge_set: got %h expected 00000003", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_disabled: got %b expected 0", irq); end
    applyStimulus(addrOf(3'd4), 32'h0000_0001, 1'b1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_enabled: got %b expected 1", irq); end
    applyStimulus(addrOf(3'd3), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0003) begin errors++; $display("[TB] FAIL edge_reread: got %h expected 00000003", rdata); end
    applyStimulus(addrOf(3'd4), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0001) begin errors++; $display("[TB] FAIL read_irq_en: got %h expected 00000001", rdata); end
  endtask

  task automatic test_edge_clear();
    applyStimulus(addrOf(3'd3), 32'h0000_0001, 1'b1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_clear: got %b expected 0", irq); end
    applyStimulus(addrOf(3'd3), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0002) begin errors++; $display("[TB] FAIL edge_w1c: got %h expected 00000002", rdata); end
    gpioIn = 8'h01;
    repeat (3) applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    gpioIn = 8'h03;
    repeat (2) applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    applyStimulus(addrOf(3'd3), 32'h0000_0002, 1'b1);
    applyStimulus(addrOf(3'd3), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0002) begin errors++; $display("[TB] FAIL set_wins: got %h expected 00000002", rdata); end
    applyStimulus(addrOf(3'd3), 32'h0000_0002, 1'b1);
    applyStimulus(addrOf(3'd3), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL edge_cleared: got %h expected 00000000", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
  endtask

  task automatic test_reserved();
    logic [31:0] expRead [8];
    expRead = '{32'h3C, 32'h0F, 32'h03, 32'h00, 32'h01, 32'h00, 32'h00, 32'h00};
    applyStimulus(addrOf(3'd5), 32'hFFFF_FFFF, 1'b1);
    applyStimulus(addrOf(3'd2), 32'h0000_00FF, 1'b1);
    applyStimulus(addrOf(3'd7), 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (gpioOut !== 8'h3C) begin errors++; $display("[TB] FAIL reserved_out_pins: got %h expected 3C", gpioOut); end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(addrOf(i[2:0]), 32'h0, 1'b0);
      checks++;
      if (rdata !== expRead[i]) begin errors++; $display("[TB] FAIL reserved_read_%0d: got %h expected %h", i, rdata, expRead[i]); end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(addrOf(3'd0), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_003C) begin errors++; $display("[TB] FAIL b2b_out: got %h expected 0000003c", rdata); end
    applyStimulus(addrOf(3'd1), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_000F) begin errors++; $display("[TB] FAIL b2b_dir: got %h expected 0000000f", rdata); end
    applyStimulus(addrOf(3'd2), 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000_0003) begin errors++; $display("[TB] FAIL b2b_in: got %h expected 00000003", rdata); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    addr   = '0;
    wdata  = '0;
    we     = 1'b0;
    gpioIn = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_out_dir();
    test_edge_irq();
    test_edge_clear();
    test_reserved();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_responder.md
# gpio_responder

Memory-mapped GPIO peripheral sitting on the responder side of the core's data bus, behind the bus interconnect's region-2 decode (addresses 0x2000_0000–0x2FFF_FFFF). It accepts word writes qualified by the interconnect's GPIO write enable and returns registered read data one cycle after the address, matching the interconnect's registered read-select. It drives output pins and output enables, synchronizes input pins, latches rising edges and raises a level interrupt.

## Interface
- WIDTH, 32, bus data/address width
- NPINS, 8, number of GPIO pins (1..WIDTH); unused upper register bits read 0
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  WIDTH  byte address from core; only addr[4:2] decoded
- wdata  in  WIDTH  write data
- we  in  1  write enable (interconnect we_gpio, already region-qualified)
- rdata  out  WIDTH  registered read data (to interconnect rdata_gpio)
- gpio_in  in  NPINS  asynchronous pin inputs
- gpio_out  out  NPINS  output pin values
- gpio_oe  out  NPINS  output enables, 1 = drive
- irq  out  1  interrupt request, level

## Operation
- Register map by addr[4:2]: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 EDGE (RW1C), 4 IRQ_EN (RW), 5–7 reserved (read 0, writes ignored).
- Writes: full word, take effect on the rising edge where we=1; wdata[NPINS-1:0] used, upper bits dropped. Writes to IN ignored.
- EDGE: bit i set when synchronized gpio_in[i] is 1 and its previous sampled value 0; writing 1 clears bit i, writing 0 leaves it. Simultaneous set and clear on same bit in same cycle: set wins.
- irq = |(EDGE & IRQ_EN[NPINS-1:0]), combinational from registers, no glitch from bus inputs.
- gpio_out = OUT, gpio_oe = DIR, directly from registers. IN reflects pins regardless of DIR.
- Reads: every cycle rdata <= zero-extended register selected by addr[4:2]; no read enable; reads have no side effects (EDGE not cleared on read).
- Reset: OUT, DIR, EDGE, IRQ_EN, rdata, both synchronizer stages and previous-value register all 0; hence gpio_out=0, gpio_oe=0, irq=0. Reset asserted mid-write discards the write.

## Timing
- Read latency 1: addr presented in cycle n, rdata valid in cycle n+1 (after edge ending n).
- Write to read: write at edge k, read of same address presented in cycle k+1 returns new value in cycle k+2; gpio_out/gpio_oe change right after edge k.
- Read and write of same register in same cycle: rdata returns old value.
- Input path: 2-flop synchronizer. Pin stable high before edge k -> IN reads 1 from data captured at edge k+1 -> EDGE bit set at edge k+2 -> irq high after edge k+2 if enabled.
- Pulse shorter than one clock may be missed; pulse ≥2 cycles always flagged once.

## Structure
- Package gpio_pkg: register offset constants (GPIO_OUT=0, GPIO_DIR=1, GPIO_IN=2, GPIO_EDGE=3, GPIO_IRQ_EN=4), region id 4'd2.
- Sub-module gpio_sync: per-vector 2-flop synchronizer plus previous-value register, outputs sync value and rise pulse; instantiated once with width NPINS.

## Test plan
- Reset: assert rst async mid-cycle -> gpio_out=0, gpio_oe=0, irq=0, rdata=0 immediately; all register reads return 0 after release.
- Write OUT=0xA5, DIR=0x0F -> gpio_out=0xA5, gpio_oe=0x0F next cycle; reads return 0x0000_00A5 and 0x0000_000F one cycle after address; write 0xFFFF_FF5A to OUT reads 0x5A.
- Drive gpio_in=0x03 at cycle 0 -> IN reads 0x03 from cycle 2 data, EDGE=0x03 after edge 2; irq stays 0 until IRQ_EN=0x01 written, then irq=1.
- Write EDGE=0x01 -> EDGE=0x02, irq=0 with IRQ_EN=0x01; write EDGE=0x02 in same cycle a new rise on pin 1 is detected -> bit 1 stays 1.
- Write to address offset 0x14 and to IN -> no register changes; reads of 0x14–0x1C return 0; read of EDGE twice -> same value (no clear-on-read).
- Back-to-back: read OUT, DIR, IN on consecutive cycles -> rdata pipelined values on following consecutive cycles, one per cycle.
